// File: rtl/sample_stream_receiver_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sample_stream_receiver_if                                     |
// | Description : Link (SCL/SS/MOSI) and FIFO read-side signal bundle for the   |
// |               sample stream receiver.                                       |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
interface sample_stream_receiver_if #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 4
);
  // Serial link, driven by the transmitting parent
  logic                     SCL;
  logic                     SS;
  logic                     MOSI;
  // Local FIFO read port
  logic                     rd_en;
  logic [DATA_W-1:0]        rd_data;
  logic                     rd_valid;
  logic                     empty;
  logic                     full;
  logic [$clog2(DEPTH):0]   count;
  logic                     frame_err;
  logic                     overflow;

  // Link driver and sample consumer side
  modport master (
    output SCL, SS, MOSI, rd_en,
    input  rd_data, rd_valid, empty, full, count, frame_err, overflow
  );

  // Receiver side
  modport slave (
    input  SCL, SS, MOSI, rd_en,
    output rd_data, rd_valid, empty, full, count, frame_err, overflow
  );
endinterface
`default_nettype wire

// File: rtl/sample_stream_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sample_stream_receiver                                        |
// | Description : Oversampling receiver for the 12-bit sample write link.       |
// |               Synchronises SCL/SS/MOSI, deserialises MSB-first frames and   |
// |               queues good samples in a small circular FIFO.                 |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module sample_stream_receiver #(
  parameter int DATA_W      = 12,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic                clk,
  input  wire logic                rst,    // asynchronous, active-low
  sample_stream_receiver_if.slave  bus
);

  localparam int              AW        = $clog2(DEPTH);
  localparam int              CW        = $clog2(DATA_W + 1);
  localparam logic [CW-1:0]   LAST_BIT  = CW'(DATA_W - 1);
  localparam logic [AW:0]     FULL_CNT  = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RECV     = 2'd1,
    ST_WAIT_END = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] scl_sync_q,  scl_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q,   ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   scl_prev_q,  scl_prev_d;
  logic                   ss_prev_q,   ss_prev_d;

  logic scl_s, ss_s, mosi_s;
  logic scl_rise, ss_fall, ss_rise;

  // Next values of the synchroniser chains and their one-cycle-delayed copies
  always_comb begin
    scl_sync_d  = {scl_sync_q[SYNC_STAGES-2:0],  bus.SCL};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0],   bus.SS};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.MOSI};
    scl_prev_d  = scl_sync_q[SYNC_STAGES-1];
    ss_prev_d   = ss_sync_q[SYNC_STAGES-1];
  end

  // Synchroniser registers. SS resets low so that a link already held low when
  // reset is released produces no falling edge: a frame can only start after
  // SS has been seen high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync_q  <= '0;
      ss_sync_q   <= '0;
      mosi_sync_q <= '0;
      scl_prev_q  <= 1'b0;
      ss_prev_q   <= 1'b0;
    end else begin
      scl_sync_q  <= scl_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      scl_prev_q  <= scl_prev_d;
      ss_prev_q   <= ss_prev_d;
    end
  end

  // Edge detection on the synchronised values
  always_comb begin
    scl_s    = scl_sync_q[SYNC_STAGES-1];
    ss_s     = ss_sync_q[SYNC_STAGES-1];
    mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    scl_rise = scl_s & ~scl_prev_q;
    ss_fall  = ~ss_s & ss_prev_q;
    ss_rise  = ss_s & ~ss_prev_q;
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_t            state_q,      state_d;
  logic [DATA_W-1:0] shift_q,      shift_d;
  logic [CW-1:0]     bit_cnt_q,    bit_cnt_d;
  logic              long_flag_q,  long_flag_d;
  logic              push_q,       push_d;
  logic [DATA_W-1:0] push_data_q,  push_data_d;
  logic              frame_err_q,  frame_err_d;

  // Next-state, shift and push-request logic for the frame decoder
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    long_flag_d = long_flag_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    frame_err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        shift_d     = '0;
        bit_cnt_d   = '0;
        long_flag_d = 1'b0;
        // An SCL rise coincident with the SS fall is deliberately not counted
        if (ss_fall) begin
          state_d = ST_RECV;
        end
      end

      ST_RECV: begin
        if (ss_rise) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (scl_rise) begin
          shift_d   = {shift_q[DATA_W-2:0], mosi_s};
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (bit_cnt_q == LAST_BIT) begin
            state_d = ST_WAIT_END;
          end
        end
      end

      ST_WAIT_END: begin
        if (ss_rise) begin
          if (long_flag_q) begin
            frame_err_d = 1'b1;
          end else begin
            push_d      = 1'b1;
            push_data_d = shift_q;
          end
          state_d = ST_IDLE;
        end else if (scl_rise) begin
          // Extra clock: remember it, but keep the captured sample intact
          long_flag_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Frame decoder registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      long_flag_q <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      long_flag_q <= long_flag_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sample FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q,   rd_ptr_d;
  logic [AW:0]       count_q,    count_d;
  logic              empty_q,    empty_d;
  logic              full_q,     full_d;
  logic [DATA_W-1:0] rd_data_q,  rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic              pop_ok, push_ok;

  // Push/pop arbitration. A pop in the same cycle frees a slot, so a push into
  // a full FIFO is still accepted; a pop from an empty FIFO never happens.
  always_comb begin
    pop_ok     = bus.rd_en && (count_q != '0);
    push_ok    = push_q && ((count_q != FULL_CNT) || pop_ok);

    wr_ptr_d   = push_ok ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d   = pop_ok  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;

    count_d    = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + (AW + 1)'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - (AW + 1)'(1);
    end

    empty_d    = (count_d == '0);
    full_d     = (count_d == FULL_CNT);
    rd_data_d  = pop_ok ? mem_q[rd_ptr_q] : rd_data_q;
    rd_valid_d = pop_ok;
    overflow_d = overflow_q | (push_q & ~push_ok);
  end

  // FIFO storage; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_q;
    end
  end

  // FIFO pointers, occupancy and registered read-side outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.empty     = empty_q;
  assign bus.full      = full_q;
  assign bus.count     = count_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_sample_stream_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sample_stream_receiver                                     |
// | Description : Directed self-checking bench for sample_stream_receiver.      |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_sample_stream_receiver;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;   // 50 MHz

  sample_stream_receiver_if #(.DATA_W(12), .DEPTH(4)) bus ();

  sample_stream_receiver #(
    .DATA_W      (12),
    .DEPTH       (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_checks   = 0;
  int          n_fail     = 0;
  int          err_pulses = 0;
  logic [11:0] sb [$];

  // Count frame_err pulses
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.frame_err === 1'b1) err_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [31:0] val, input int n, input int half);
    for (int i = n - 1; i >= 0; i--) begin
      bus.MOSI = val[i];
      wait_clk(half);
      bus.SCL = 1'b1;
      wait_clk(half);
      bus.SCL = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [31:0] val, input int n, input int half);
    bus.SS = 1'b0;
    wait_clk(half);
    shift_bits(val, n, half);
    wait_clk(half);
    bus.SS = 1'b1;
    wait_clk(8);
  endtask

  // Good 12-bit frame; the scoreboard only expects it back if there was room
  task automatic send_good(input logic [11:0] val);
    if (sb.size() < 4) sb.push_back(val);
    send_frame({20'd0, val}, 12, 10);
  endtask

  task automatic pop_check(input string tag);
    logic [11:0] exp;
    int          c0;
    c0 = int'(bus.count);
    check({tag, "_sb_nonempty"}, (sb.size() != 0), 1);
    exp = (sb.size() != 0) ? sb.pop_front() : 12'h000;
    bus.rd_en = 1'b1;
    wait_clk(1);
    bus.rd_en = 1'b0;
    check({tag, "_rd_valid"}, bus.rd_valid, 1);
    check({tag, "_rd_data"},  bus.rd_data,  exp);
    check({tag, "_count"},    bus.count,    c0 - 1);
  endtask

  initial begin
    logic [11:0] fill [5];
    int          e0;
    logic [11:0] exp;

    fill = '{12'h001, 12'h002, 12'h003, 12'h004, 12'hFFF};

    // Reset state
    rst = 1'b0;
    bus.SS = 1'b1; bus.SCL = 1'b0; bus.MOSI = 1'b0; bus.rd_en = 1'b0;
    wait_clk(3);
    check("rst_empty",     bus.empty,     1);
    check("rst_full",      bus.full,      0);
    check("rst_count",     bus.count,     0);
    check("rst_rd_valid",  bus.rd_valid,  0);
    check("rst_rd_data",   bus.rd_data,   0);
    check("rst_frame_err", bus.frame_err, 0);
    check("rst_overflow",  bus.overflow,  0);
    rst = 1'b1;
    wait_clk(5);

    // Frame 0xA5C at 100 kHz, with push latency measured from the SS pin edge
    bus.SS = 1'b0;
    wait_clk(250);
    shift_bits(32'hA5C, 12, 250);
    wait_clk(250);
    bus.SS = 1'b1;
    sb.push_back(12'hA5C);
    wait_clk(3);
    check("lat_count_before", bus.count, 0);
    wait_clk(1);
    check("lat_count_after",  bus.count, 1);
    check("a5c_not_empty",    bus.empty, 0);
    wait_clk(4);
    pop_check("a5c");
    check("a5c_empty_after",  bus.empty, 1);

    // Five frames with no reads: the fifth overflows
    foreach (fill[i]) send_good(fill[i]);
    check("fill_full",     bus.full,     1);
    check("fill_count",    bus.count,    4);
    check("fill_overflow", bus.overflow, 1);
    for (int i = 0; i < 4; i++) pop_check("fill_pop");
    check("fill_empty",        bus.empty,    1);
    check("fill_ovf_sticky",   bus.overflow, 1);

    // Reset after 6 bits, released while SS stays low
    e0 = err_pulses;
    bus.SS = 1'b0;
    wait_clk(10);
    shift_bits(32'h7E1 >> 6, 6, 10);
    rst = 1'b0;
    wait_clk(3);
    check("midrst_overflow", bus.overflow, 0);
    check("midrst_count",    bus.count,    0);
    rst = 1'b1;
    wait_clk(5);
    shift_bits(32'h21, 6, 10);
    wait_clk(10);
    bus.SS = 1'b1;
    wait_clk(8);
    check("midrst_no_push", bus.count, 0);
    check("midrst_no_err",  err_pulses, e0);
    send_good(12'h7E1);
    check("r7e1_count", bus.count, 1);
    pop_check("r7e1");

    // Short frame of 8 bits, then a good frame
    e0 = err_pulses;
    send_frame(32'hAB, 8, 10);
    check("short_err_pulse", err_pulses, e0 + 1);
    check("short_count",     bus.count,  0);
    send_good(12'h3C3);
    pop_check("r3c3");

    // Long frame of 13 bits
    e0 = err_pulses;
    send_frame(32'h1ABC, 13, 10);
    check("long_err_pulse", err_pulses,   e0 + 1);
    check("long_count",     bus.count,    0);
    check("long_overflow",  bus.overflow, 0);

    // FIFO full, pop lands in the push cycle of 0x555
    for (int i = 0; i < 4; i++) send_good(12'h100 + 12'(i));
    check("pp_full", bus.full, 1);
    bus.SS = 1'b0;
    wait_clk(10);
    shift_bits(32'h555, 12, 10);
    wait_clk(10);
    bus.SS = 1'b1;
    wait_clk(3);
    exp = sb.pop_front();
    sb.push_back(12'h555);
    bus.rd_en = 1'b1;
    wait_clk(1);
    bus.rd_en = 1'b0;
    check("pp_rd_valid", bus.rd_valid, 1);
    check("pp_rd_data",  bus.rd_data,  exp);
    check("pp_count",    bus.count,    4);
    check("pp_overflow", bus.overflow, 0);
    wait_clk(8);
    for (int i = 0; i < 4; i++) pop_check("pp_pop");
    check("pp_empty", bus.empty, 1);

    // rd_en while empty is ignored
    bus.rd_en = 1'b1;
    wait_clk(1);
    bus.rd_en = 1'b0;
    check("empty_rd_valid", bus.rd_valid, 0);
    check("empty_rd_data",  bus.rd_data,  12'h555);
    check("empty_count",    bus.count,    0);
    check("total_err_pulses", err_pulses, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
